// File: rtl/mic_array_pkg.sv
// Shared types and constants for the microphone-array capture path.
package mic_array_pkg;

   localparam int unsigned SAMPLE_W  = 16;
   localparam int unsigned MAX_RETRY = 4;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StSampleA,
      StSampleB,
      StPush
   } cap_state_t;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } stereo_pair_t;

endpackage

// File: rtl/mic_pair_fifo.sv
// Show-ahead synchronous FIFO; an extra pointer bit separates full from empty.
module mic_pair_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             valid,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign valid   = (wr_ptr_q != rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && valid;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push && (!full || do_pop);
   assign head    = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mic_pair_capture.sv
// Moves each completed I2S stereo pair into the clk domain: detects frame end on ws,
// waits for the receiver registers to settle, double-samples them and queues the pair.
module mic_pair_capture
   import mic_array_pkg::*;
#(
   parameter int unsigned WIDTH       = SAMPLE_W,
   parameter int unsigned SETTLE      = 12,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SKIP_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ws,
   input  logic [WIDTH-1:0] data_left,
   input  logic [WIDTH-1:0] data_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             overflow,
   output logic [7:0]       drop_count
);

   localparam int unsigned CW  = $clog2(SETTLE + 1);
   localparam int unsigned RW  = $clog2(MAX_RETRY);
   localparam int unsigned SKW = $clog2(SKIP_FRAMES + 2);
   localparam int unsigned PW  = 2 * WIDTH;

   logic            ws_s1_q, ws_s2_q, ws_hist_q, ws_fall_q;
   cap_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [SKW-1:0]  skip_q, skip_d;
   logic [PW-1:0]   sample, cap_a_q, cap_b_q, head;
   logic            wr_req, fifo_full, fifo_pop, drop;
   logic            overflow_q;
   logic [7:0]      drop_count_q;

   assign sample = {data_left, data_right};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_s1_q   <= 1'b0;
         ws_s2_q   <= 1'b0;
         ws_hist_q <= 1'b0;
         ws_fall_q <= 1'b0;
      end else begin
         ws_s1_q   <= ws;
         ws_s2_q   <= ws_s1_q;
         ws_hist_q <= ws_s2_q;
         ws_fall_q <= ws_hist_q && !ws_s2_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      skip_d  = skip_q;
      wr_req  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ws_fall_q) begin
               cnt_d   = CW'(SETTLE - 1);
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (cnt_q == '0) begin
               retry_d = '0;
               state_d = StSampleA;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StSampleA: state_d = StSampleB;
         StSampleB: begin
            // Sample arriving now lands in capture B; it must match capture A.
            if (cap_a_q == sample) begin
               state_d = StPush;
            end else if (retry_q == RW'(MAX_RETRY - 1)) begin
               state_d = StIdle;
            end else begin
               retry_d = retry_q + 1'b1;
               state_d = StSampleA;
            end
         end
         StPush: begin
            state_d = StIdle;
            if (skip_q != '0) skip_d = skip_q - 1'b1;
            else              wr_req = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         retry_q <= '0;
         skip_q  <= SKW'(SKIP_FRAMES);
         cap_a_q <= '0;
         cap_b_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         skip_q  <= skip_d;
         if (state_q == StSampleA) cap_a_q <= sample;
         if (state_q == StSampleB) cap_b_q <= sample;
      end
   end

   mic_pair_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_req),
      .push_data (cap_b_q),
      .pop       (out_ready),
      .full      (fifo_full),
      .valid     (out_valid),
      .head      (head)
   );

   assign fifo_pop = out_valid && out_ready;
   assign drop     = wr_req && fifo_full && !fifo_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         overflow_q <= drop;
         if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 1'b1;
      end
   end

   assign out_left   = head[PW-1:WIDTH];
   assign out_right  = head[WIDTH-1:0];
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: doc/mic_pair_capture.md
# mic_pair_capture

Moves each completed stereo sample pair from the two-mic I2S receiver (bit-clock domain) into the system clock domain. Detects end-of-frame from the raw word-select line, waits for the receiver's output registers to settle, double-samples them for stability, and queues the `{left, right}` pair in a small FIFO. The FIFO is drained over a valid/ready handshake by the downstream beamforming/filter stage. Sits directly after the I2S receiver, one instance per mic pair.

## Interface
- `WIDTH`, 16: sample width; must match the receiver's `width`.
- `SETTLE`, 12: `clk` cycles waited after a synchronized `ws` falling edge before sampling; must cover ≥2 `sck` periods plus margin.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `SKIP_FRAMES`, 2: completed frames discarded after reset (partial first words).
- `clk`  in  1  system clock. One clock only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ws`  in  1  raw I2S word select, asynchronous to `clk`.
- `data_left`  in  WIDTH  receiver left register, asynchronous, quasi-static.
- `data_right`  in  WIDTH  receiver right register, asynchronous, quasi-static.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head.
- `out_left`  out  WIDTH  head left sample.
- `out_right`  out  WIDTH  head right sample.
- `overflow`  out  1  one-cycle pulse when a pair is dropped.
- `drop_count`  out  8  saturating count of dropped pairs.

## Operation
- `ws` passes through a 2-flop synchronizer plus one history flop. A falling edge (history=1, current=0) marks frame end: the receiver has just latched `data_right`, and `data_left` was latched at the prior rising edge.
- FSM states:
  - IDLE: on falling edge, load settle counter with `SETTLE-1` and go to SETTLE.
  - SETTLE: decrement each cycle; at 0 go to SAMPLE_A.
  - SAMPLE_A: register `{data_left, data_right}` into capture A; go to SAMPLE_B.
  - SAMPLE_B: register into capture B; if A==B go to PUSH, otherwise go back to SAMPLE_A.
  - After 4 consecutive mismatches, return to IDLE with no push and no overflow. This is the glitch guard.
  - PUSH: if the skip counter is nonzero, decrement it and push nothing. Otherwise write B into the FIFO if not full; if full, drop the pair, pulse `overflow`, and increment `drop_count` (saturates at 255). Then go to IDLE.
- `ws` falling edges seen outside IDLE are ignored. A half-frame is ≫ SETTLE+8 cycles under the required clock ratio.
- FIFO: show-ahead; `out_left`/`out_right` are valid whenever `out_valid`=1. A pop occurs on `out_valid && out_ready`.
  - Push and pop in the same cycle while full: the pop frees a slot and the push succeeds. No overflow is raised.
  - Push while empty: data appears on the next cycle. There is no fall-through in the same cycle.
- Clock requirement: `clk` ≥ 4× `sck` frequency.

## Timing
- Reset values:
  - outputs: `out_valid`=0, `out_left`=`out_right`=0, `overflow`=0, `drop_count`=0.
  - internal: FSM=IDLE, skip counter=`SKIP_FRAMES`, FIFO empty, synchronizer flops=0.
- Latency from the `ws` falling edge at the synchronizer input to `out_valid`=1, with an empty FIFO and a stable first compare: 2 (sync) + 1 (edge) + SETTLE + 2 (A, B) + 1 (PUSH) + 1 (FIFO) = SETTLE+7 cycles. Default: 19.
- Throughput: one pair per frame; a new pair can be accepted every cycle on the output.
- Reset asserted mid-operation: immediately clears the FIFO and the FSM; any pair in flight is lost. After release, `SKIP_FRAMES` frames are skipped again.
- `drop_count` is not cleared on read; only reset clears it.

## Structure
- Package `mic_array_pkg`: `SAMPLE_W`=16, the `cap_state_t` enum (IDLE, SETTLE, SAMPLE_A, SAMPLE_B, PUSH), `MAX_RETRY`=4, and the `stereo_pair_t` struct `{left, right}`.
- Sub-module `mic_pair_fifo`: synchronous FIFO, parameterized by DEPTH, with one extra pointer bit for the full/empty decode. It is separately testable.
- The top level holds the synchronizer, FSM, capture registers and drop counter.

## Test plan
- Reset, then 3 frames of L=0x1234/R=0xABCD with `out_ready`=1:
  - frames 1–2 are skipped;
  - frame 3 produces exactly one beat 0x1234/0xABCD, with `out_valid` rising SETTLE+7 cycles after `ws` falls.
- `out_ready`=0 for 6 frames with distinct pairs 0x0001..0x0006 after the skip: the FIFO holds 1–4; frames 5 and 6 each pulse `overflow` and `drop_count`=2. Releasing `out_ready` yields 1,2,3,4 in order.
- FIFO full, with a pop coinciding with the PUSH cycle: no overflow, and the new pair is the last beat out.
- `data_left` toggles during SAMPLE_A/B: 0x00FF then 0xFF00, then stable at 0x0F0F. The retry captures 0x0F0F. With more than 4 mismatches, no beat and no overflow.
- Assert `rst_n` during SETTLE with 2 entries queued: `out_valid`=0 immediately and `drop_count`=0. The next beat appears only after `SKIP_FRAMES`+1 frames.
- 300 dropped pairs: `drop_count` saturates at 255.
